led_pingpong_ram: RTL and testbench

//  Two-bank (ping-pong) simple dual-port RAM for per-LED colour data, CH_NUM channels

---
 rtl/led_pingpong_ram.sv | 160 ++++++++++++++++
 tb/tb_led_pingpong_ram.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pingpong_ram.sv
// Two-bank (ping-pong) simple dual-port RAM holding per-LED colour words.
// The capture side writes the write bank while the LED driver reads the
// display bank (~wr_bank). A swap exchanges the banks; a clear engine zeroes
// the write bank one word per cycle, and a swap requested meanwhile is held
// until the clear finishes.
module led_pingpong_ram #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 20,
   parameter int CH_NUM     = 3,
   parameter int OUT_REG    = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [CH_NUM*DATA_WIDTH-1:0]   wr_data,
   input  logic [CH_NUM-1:0]              wr_ch_en,
   input  logic                           rd_en,
   input  logic [ADDR_WIDTH-1:0]          rd_addr,
   output logic [CH_NUM*DATA_WIDTH-1:0]   rd_data,
   output logic                           rd_valid,
   input  logic                           swap_req,
   input  logic                           clr_req,
   output logic                           busy,
   output logic                           wr_bank,
   output logic [7:0]                     frame_cnt
);

   localparam int W     = CH_NUM * DATA_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                  pend_q, pend_d;
   logic                  bank_q, bank_d;
   logic [7:0]            frame_q, frame_d;

   // single write port shared by capture writes and the clear engine
   logic                  mem_we;
   logic [ADDR_WIDTH:0]   mem_waddr;
   logic [W-1:0]          mem_wdata;
   logic [CH_NUM-1:0]     mem_wmask;

   // both banks live in one array; the bank bit is the address MSB
   logic [W-1:0]          mem [0:2*DEPTH-1];

   logic                  rd1_vld_q;
   logic [W-1:0]          rd1_data_q;

   // control state: FSM, clear counter, deferred swap, bank and frame count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
         pend_q    <= 1'b0;
         bank_q    <= 1'b0;
         frame_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         pend_q    <= pend_d;
         bank_q    <= bank_d;
         frame_q   <= frame_d;
      end
   end

   // next state plus write-port steering; the bank bit used here is the
   // pre-swap value, so same-cycle writes/clears land in the old write bank
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      pend_d    = pend_q;
      bank_d    = bank_q;
      frame_d   = frame_q;
      mem_we    = 1'b0;
      mem_waddr = {bank_q, wr_addr};
      mem_wdata = wr_data;
      mem_wmask = wr_ch_en;
      case (state_q)
         IDLE: begin
            mem_we = wr_en;
            if (clr_req) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
               pend_d    = swap_req;
            end else if (swap_req) begin
               bank_d  = ~bank_q;
               frame_d = frame_q + 8'd1;
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = {bank_q, clr_cnt_q};
            mem_wdata = '0;
            mem_wmask = '1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (swap_req) pend_d = 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = IDLE;
               if (pend_q || swap_req) begin
                  bank_d  = ~bank_q;
                  frame_d = frame_q + 8'd1;
                  pend_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM write with per-channel byte-lane style enables; contents not reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < CH_NUM; k++) begin
            if (mem_wmask[k])
               mem[mem_waddr][k*DATA_WIDTH +: DATA_WIDTH] <= mem_wdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // first read stage from the display bank; data holds when no read issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1_vld_q  <= 1'b0;
         rd1_data_q <= '0;
      end else begin
         rd1_vld_q <= rd_en;
         if (rd_en) rd1_data_q <= mem[{~bank_q, rd_addr}];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic         rd2_vld_q;
         logic [W-1:0] rd2_data_q;
         // optional output register stage for timing
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd2_vld_q  <= 1'b0;
               rd2_data_q <= '0;
            end else begin
               rd2_vld_q <= rd1_vld_q;
               if (rd1_vld_q) rd2_data_q <= rd1_data_q;
            end
         end
         assign rd_valid = rd2_vld_q;
         assign rd_data  = rd2_data_q;
      end else begin : g_noreg
         assign rd_valid = rd1_vld_q;
         assign rd_data  = rd1_data_q;
      end
   endgenerate

   assign busy      = (state_q == CLEAR) | pend_q;
   assign wr_bank   = bank_q;
   assign frame_cnt = frame_q;

endmodule

// File: tb/tb_led_pingpong_ram.sv
// Directed bench for led_pingpong_ram: a bank-level model (two word arrays,
// a clear countdown and a pending-swap flag) is stepped on each edge and
// compared with the DUT every cycle; literal expectations pin key points.
module tb_led_pingpong_ram;
   localparam int AW = 7, DW = 20, CH = 3, W = 60, DEPTH = 128;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          wr_en = 0, rd_en = 0, swap_req = 0, clr_req = 0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic [CH-1:0] wr_ch_en = '0;
   logic [W-1:0]  rd_data;
   logic          rd_valid, busy, wr_bank;
   logic [7:0]    frame_cnt;

   led_pingpong_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CH_NUM(CH), .OUT_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ch_en(wr_ch_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .swap_req(swap_req), .clr_req(clr_req), .busy(busy),
      .wr_bank(wr_bank), .frame_cnt(frame_cnt));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   bit run = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- model ----
   logic [W-1:0]  mmem [2][DEPTH];
   logic [CH-1:0] mknown [2][DEPTH];
   int            m_bank, m_frame, clr_left, m_pend;
   logic [W-1:0]  e_data;
   bit            e_dknown, e_valid;

   initial begin
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < DEPTH; a++) mknown[b][a] = '0;
   end

   always @(posedge clk or negedge rst_n) begin
      int b, a;
      if (!rst_n) begin
         m_bank = 0; m_frame = 0; clr_left = 0; m_pend = 0;
         e_data = '0; e_dknown = 1; e_valid = 0;
      end else begin
         b = m_bank;
         if (rd_en) begin
            e_valid = 1;
            if (mknown[1-b][rd_addr] == '1) begin
               e_data = mmem[1-b][rd_addr]; e_dknown = 1;
            end else e_dknown = 0;
         end else e_valid = 0;
         if (clr_left > 0) begin
            a = DEPTH - clr_left;
            mmem[b][a] = '0; mknown[b][a] = '1;
            clr_left--;
            if (swap_req) m_pend = 1;
            if (clr_left == 0 && m_pend != 0) begin
               m_bank = 1 - b; m_frame = (m_frame + 1) % 256; m_pend = 0;
            end
         end else begin
            if (wr_en)
               for (int k = 0; k < CH; k++)
                  if (wr_ch_en[k]) begin
                     mmem[b][wr_addr][k*DW +: DW] = wr_data[k*DW +: DW];
                     mknown[b][wr_addr][k] = 1'b1;
                  end
            if (clr_req) begin
               clr_left = DEPTH; m_pend = swap_req ? 1 : 0;
            end else if (swap_req) begin
               m_bank = 1 - b; m_frame = (m_frame + 1) % 256;
            end
         end
      end
   end

   // ---- per-cycle compare ----
   always @(negedge clk) begin
      if (run) begin
         chk("rd_valid", {63'd0, rd_valid}, {63'd0, e_valid});
         if (e_dknown) chk("rd_data", {4'd0, rd_data}, {4'd0, e_data});
         chk("wr_bank", {63'd0, wr_bank}, m_bank);
         chk("frame_cnt", {56'd0, frame_cnt}, m_frame);
         chk("busy", {63'd0, busy}, (clr_left > 0 || m_pend != 0) ? 64'd1 : 64'd0);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
      wr_en = 0; rd_en = 0; swap_req = 0; clr_req = 0;
   endtask

   task automatic wr(input int a, input logic [W-1:0] d, input logic [CH-1:0] m);
      wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_ch_en = m; cyc();
   endtask

   task automatic rd(input int a);
      rd_en = 1; rd_addr = AW'(a); cyc();
   endtask

   task automatic swp();
      swap_req = 1; cyc();
   endtask

   initial begin
      int bcnt, tog;
      logic pb;
      #2 run = 1;
      @(posedge clk); #1;
      chk("rst rd_data", {4'd0, rd_data}, 64'd0);
      chk("rst rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("rst busy", {63'd0, busy}, 64'd0);
      chk("rst wr_bank", {63'd0, wr_bank}, 64'd0);
      chk("rst frame", {56'd0, frame_cnt}, 64'd0);
      rst_n = 1;
      cyc();

      // 1) basic write / swap / read
      wr(5, 60'h00003_00002_00001, 3'b111);
      swp();
      rd(5);
      chk("t1 rd_data", {4'd0, rd_data}, 64'h00003_00002_00001);
      chk("t1 rd_valid", {63'd0, rd_valid}, 64'd1);
      chk("t1 frame", {56'd0, frame_cnt}, 64'd1);
      chk("t1 wr_bank", {63'd0, wr_bank}, 64'd1);

      // 2) per-channel enable: bring word 5 back into the write bank, patch ch1
      swp();
      wr(5, {W{1'b1}}, 3'b010);
      swp();
      rd(5);
      chk("t2 rd_data", {4'd0, rd_data}, 64'h00003_FFFFF_00001);

      // 3) clear: fill write bank with ones, clear while hammering writes
      for (int i = 0; i < DEPTH; i++) wr(i, {W{1'b1}}, 3'b111);
      clr_req = 1; cyc();
      bcnt = 0;
      for (int i = 0; i < 300; i++) begin
         if (!busy) break;
         bcnt++;
         wr_en = 1; wr_addr = AW'($urandom_range(0, DEPTH-1)); wr_data = {W{1'b1}}; wr_ch_en = 3'b111;
         cyc();
      end
      chk("t3 busy cycles", bcnt, 64'd128);
      swp();
      for (int i = 0; i < DEPTH; i++) rd(i);
      chk("t3 last word zero", {4'd0, rd_data}, 64'd0);
      chk("t3 frame", {56'd0, frame_cnt}, 64'd4);

      // 4) swap requests at clear cycles 10/20/30 collapse into one swap
      clr_req = 1; cyc();
      tog = 0; pb = wr_bank;
      for (int i = 1; i < 300; i++) begin
         if (!busy) break;
         swap_req = (i == 10 || i == 20 || i == 30);
         cyc();
         if (wr_bank !== pb) tog++;
         pb = wr_bank;
      end
      chk("t4 toggles", tog, 64'd1);
      chk("t4 wr_bank", {63'd0, wr_bank}, 64'd1);
      chk("t4 frame", {56'd0, frame_cnt}, 64'd5);

      // 5) same-cycle swap + write + read of addr 9
      wr(9, 60'h0000B_0000B_0000B, 3'b111);
      swp();
      swap_req = 1; wr_en = 1; wr_addr = 7'd9; wr_data = 60'h0000C_0000C_0000C; wr_ch_en = 3'b111;
      rd_en = 1; rd_addr = 7'd9;
      cyc();
      chk("t5 old display", {4'd0, rd_data}, 64'h0000B_0000B_0000B);
      rd(9);
      chk("t5 new data", {4'd0, rd_data}, 64'h0000C_0000C_0000C);
      chk("t5 frame", {56'd0, frame_cnt}, 64'd7);

      // 6) frame counter wrap over 256 swaps
      for (int i = 0; i < 248; i++) swp();
      chk("t6 frame 255", {56'd0, frame_cnt}, 64'd255);
      swp();
      chk("t6 frame wrap", {56'd0, frame_cnt}, 64'd0);
      for (int i = 0; i < 7; i++) swp();
      chk("t6 frame 256 swaps", {56'd0, frame_cnt}, 64'd7);

      // reset in the middle of a clear with reads in flight
      clr_req = 1; cyc();
      for (int i = 1; i < 40; i++) begin
         rd_en = 1; rd_addr = AW'(i); cyc();
      end
      rd_en = 1; rd_addr = 7'd0;
      chk("t6 busy before rst", {63'd0, busy}, 64'd1);
      chk("t6 valid before rst", {63'd0, rd_valid}, 64'd1);
      #2 rst_n = 0;
      #1;
      chk("t6 rst busy", {63'd0, busy}, 64'd0);
      chk("t6 rst rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("t6 rst wr_bank", {63'd0, wr_bank}, 64'd0);
      chk("t6 rst frame", {56'd0, frame_cnt}, 64'd0);
      rd_en = 0;
      @(posedge clk); #1;
      rst_n = 1;
      cyc(); cyc();
      chk("t6 idle after rst", {63'd0, busy}, 64'd0);
      run = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
